// File: rtl/redpi_adc_frontend.sv
`default_nettype none
// ============================================================================
// Module   : redpi_adc_frontend
// Purpose  : Multi-channel fast-ADC capture front-end. Registers raw ADC
//            codes, converts offset binary to two's complement, optionally
//            decimates by 2^N with boxcar averaging, sign-extends to OUT_W
//            and keeps a sticky overrange flag per channel. Also drives the
//            constant ADC clock-control pins.
// Ports    : adc_clk      - sample clock, rising edge
//            adc_rstn     - asynchronous active-low reset
//            adc_d_i      - raw codes, channel k at [k*ADC_W +: ADC_W]
//            dec_log2     - decimation exponent (clamped to MAX_DEC_LOG2)
//            ovr_clr      - clear all sticky overrange flags
//            adc_d_o      - signed samples, channel k at [k*OUT_W +: OUT_W]
//            adc_valid_o  - one-cycle strobe, adc_d_o holds a new sample
//            adc_ovr_o    - sticky overrange flag per channel
//            adc_clk_o    - constant 2'b10 (ADC clock generation disabled)
//            adc_cdcs_o   - constant 1 (duty-cycle stabiliser enabled)
// Revision : 1.0 - initial release
// ============================================================================
module redpi_adc_frontend #(
    parameter int NCH          = 2,
    parameter int ADC_W        = 14,
    parameter int OUT_W        = 16,
    parameter int MAX_DEC_LOG2 = 4,
    parameter int OFFSET_BIN   = 1
) (
    input  logic                   adc_clk,
    input  logic                   adc_rstn,
    input  logic [NCH*ADC_W-1:0]   adc_d_i,
    input  logic [2:0]             dec_log2,
    input  logic                   ovr_clr,
    output logic [NCH*OUT_W-1:0]   adc_d_o,
    output logic                   adc_valid_o,
    output logic [NCH-1:0]         adc_ovr_o,
    output logic [1:0]             adc_clk_o,
    output logic                   adc_cdcs_o
);

    // The accumulator holds the sum of up to 2^MAX_DEC_LOG2 samples.
    localparam int               c_ACC_W    = ADC_W + MAX_DEC_LOG2;
    localparam int               c_CNT_W    = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : 1;
    localparam logic [2:0]       c_DEC_MAX  = 3'(MAX_DEC_LOG2);
    localparam logic [ADC_W-1:0] c_MSB_FLIP = (OFFSET_BIN != 0) ? {1'b1, {(ADC_W-1){1'b0}}} : '0;

    logic [NCH*ADC_W-1:0] r_raw;
    logic                 r_v0;
    logic                 r_v1;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_dec;
    logic                 r_valid;

    logic [2:0]           w_dec_eff;
    logic [2:0]           w_dec_cur;
    logic [7:0]           w_frame_max;
    logic                 w_first;
    logic                 w_last;

    assign w_dec_eff = (dec_log2 > c_DEC_MAX) ? c_DEC_MAX : dec_log2;
    assign w_first   = (r_cnt == '0);
    // A new frame length is only picked up on the first sample of a frame;
    // mid-frame the latched length governs.
    assign w_dec_cur   = w_first ? w_dec_eff : r_dec;
    assign w_frame_max = ~(8'hFF << w_dec_cur);
    assign w_last      = (8'(r_cnt) == w_frame_max);

    // Capture, valid pipeline and shared frame control.
    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            r_raw   <= '0;
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_cnt   <= '0;
            r_dec   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_raw   <= adc_d_i;
            r_v0    <= 1'b1;
            r_v1    <= r_v0;
            r_valid <= r_v1 & w_last;
            if (r_v1) begin
                if (w_first) begin
                    r_dec <= w_dec_eff;
                end
                r_cnt <= w_last ? '0 : r_cnt + c_CNT_W'(1);
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_ch
            logic [ADC_W-1:0]         w_raw;
            logic signed [ADC_W-1:0]  r_samp;
            logic                     r_ovr_det;
            logic                     r_ovr;
            logic signed [c_ACC_W-1:0] r_acc;
            logic signed [c_ACC_W-1:0] w_acc_base;
            logic signed [c_ACC_W-1:0] w_sum;
            logic signed [ADC_W-1:0]  w_mean;
            logic signed [OUT_W-1:0]  r_out;

            assign w_raw      = r_raw[k*ADC_W +: ADC_W];
            // The first sample of a frame starts a fresh sum.
            assign w_acc_base = w_first ? '0 : r_acc;
            assign w_sum      = w_acc_base + c_ACC_W'(r_samp);
            // Arithmetic shift floors toward -inf; the mean always fits ADC_W.
            assign w_mean     = ADC_W'(w_sum >>> w_dec_cur);

            always_ff @(posedge adc_clk or negedge adc_rstn) begin
                if (!adc_rstn) begin
                    r_samp    <= '0;
                    r_ovr_det <= 1'b0;
                    r_ovr     <= 1'b0;
                    r_acc     <= '0;
                    r_out     <= '0;
                end else begin
                    r_samp    <= w_raw ^ c_MSB_FLIP;
                    // Overrange is judged on the raw code: rail at either end.
                    r_ovr_det <= (&w_raw) | ~(|w_raw);
                    // Set has priority over clear.
                    r_ovr     <= (r_ovr & ~ovr_clr) | (r_ovr_det & r_v1);
                    if (r_v1 && !w_last) begin
                        r_acc <= w_sum;
                    end
                    if (r_v1 && w_last) begin
                        r_out <= OUT_W'(w_mean);
                    end
                end
            end

            assign adc_d_o[k*OUT_W +: OUT_W] = r_out;
            assign adc_ovr_o[k]              = r_ovr;
        end
    endgenerate

    assign adc_valid_o = r_valid;
    assign adc_clk_o   = 2'b10;
    assign adc_cdcs_o  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_redpi_adc_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_redpi_adc_frontend
// Purpose  : Self-checking bench for redpi_adc_frontend. A reference model
//            pushes expected strobes (edge number and channel values) into a
//            queue as stimulus is driven; a monitor pops and compares them
//            when the DUT strobes. A second instance covers a 4-channel,
//            12-bit, two's-complement-input configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_redpi_adc_frontend;

    localparam int c_MAX = 4;

    typedef struct {
        int          cyc;
        logic [15:0] d0;
        logic [15:0] d1;
    } exp_t;

    logic        adc_clk = 1'b0;
    logic        adc_rstn;
    logic [27:0] adc_d_i;
    logic [2:0]  dec_log2;
    logic        ovr_clr;
    logic [31:0] adc_d_o;
    logic        adc_valid_o;
    logic [1:0]  adc_ovr_o;
    logic [1:0]  adc_clk_o;
    logic        adc_cdcs_o;

    logic [47:0] p_d_i;
    logic [71:0] p_d_o;
    logic        p_valid;
    logic [3:0]  p_ovr;
    logic [1:0]  p_clk_o;
    logic        p_cdcs;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    exp_t        q[$];
    logic [13:0] h0[2];
    logic [13:0] h1[2];
    int          hdec[2];
    bit          hv[2];
    int          m_cnt;
    int          m_dec;
    int          m_s0;
    int          m_s1;
    logic [1:0]  exp_ovr;
    logic [31:0] last;

    always #5 adc_clk = ~adc_clk;

    redpi_adc_frontend u_dut (
        .adc_clk     (adc_clk),
        .adc_rstn    (adc_rstn),
        .adc_d_i     (adc_d_i),
        .dec_log2    (dec_log2),
        .ovr_clr     (ovr_clr),
        .adc_d_o     (adc_d_o),
        .adc_valid_o (adc_valid_o),
        .adc_ovr_o   (adc_ovr_o),
        .adc_clk_o   (adc_clk_o),
        .adc_cdcs_o  (adc_cdcs_o)
    );

    redpi_adc_frontend #(
        .NCH          (4),
        .ADC_W        (12),
        .OUT_W        (18),
        .MAX_DEC_LOG2 (4),
        .OFFSET_BIN   (0)
    ) u_par (
        .adc_clk     (adc_clk),
        .adc_rstn    (adc_rstn),
        .adc_d_i     (p_d_i),
        .dec_log2    (3'd0),
        .ovr_clr     (1'b0),
        .adc_d_o     (p_d_o),
        .adc_valid_o (p_valid),
        .adc_ovr_o   (p_ovr),
        .adc_clk_o   (p_clk_o),
        .adc_cdcs_o  (p_cdcs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int s14(input logic [13:0] raw);
        logic [13:0] c;
        c = raw ^ 14'h2000;
        return int'($signed(c));
    endfunction

    function automatic logic ovr14(input logic [13:0] raw);
        return (raw == 14'h3FFF) || (raw == 14'h0000);
    endfunction

    function automatic logic [13:0] rnd();
        return 14'($urandom_range(16383, 0));
    endfunction

    // Drive one sample at the current time. dec is the frame length tag of
    // this sample; the port is given that value when the sample reaches the
    // decimator two edges later.
    task automatic drive_now(input logic [13:0] c0, input logic [13:0] c1,
                             input logic clr, input int dec);
        exp_t e;
        adc_d_i  = {c1, c0};
        ovr_clr  = clr;
        dec_log2 = 3'(hdec[1]);
        exp_ovr  = exp_ovr & ~{2{clr}};
        if (hv[1]) begin
            if (m_cnt == 0) begin
                m_dec = (hdec[1] > c_MAX) ? c_MAX : hdec[1];
                m_s0  = 0;
                m_s1  = 0;
            end
            m_s0 += s14(h0[1]);
            m_s1 += s14(h1[1]);
            if (m_cnt == (1 << m_dec) - 1) begin
                e.cyc = cyc + 1;
                e.d0  = 16'(m_s0 >>> m_dec);
                e.d1  = 16'(m_s1 >>> m_dec);
                q.push_back(e);
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
            exp_ovr = exp_ovr | {ovr14(h1[1]), ovr14(h0[1])};
        end
        h0[1] = h0[0];  h0[0] = c0;
        h1[1] = h1[0];  h1[0] = c1;
        hdec[1] = hdec[0];  hdec[0] = dec;
        hv[1] = hv[0];  hv[0] = 1'b1;
    endtask

    task automatic drive(input logic [13:0] c0, input logic [13:0] c1,
                         input logic clr, input int dec);
        @(negedge adc_clk);
        drive_now(c0, c1, clr, dec);
    endtask

    task automatic model_reset();
        q.delete();
        hv[0] = 1'b0;  hv[1] = 1'b0;
        m_cnt   = 0;
        exp_ovr = '0;
        last    = '0;
    endtask

    // Monitor: compare strobes against the scoreboard, the held value
    // between strobes, and the overrange flags every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge adc_clk);
            cyc++;
            #1;
            if (adc_valid_o) begin
                if (q.size() == 0) begin
                    check("strobe_extra", 32'(adc_valid_o), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("strobe_edge", 32'(cyc), 32'(e.cyc));
                    check("ch0", 32'(adc_d_o[15:0]), 32'(e.d0));
                    check("ch1", 32'(adc_d_o[31:16]), 32'(e.d1));
                    last = {e.d1, e.d0};
                end
            end else begin
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    check("strobe_missing", 32'(adc_valid_o), 32'd1);
                    void'(q.pop_front());
                end
                check("hold", adc_d_o, last);
            end
            check("ovr", 32'(adc_ovr_o), 32'(exp_ovr));
        end
    end

    logic [13:0] avg0[4] = '{14'h2001, 14'h2002, 14'h2003, 14'h2006};
    logic [47:0] p_pat[2];
    logic [17:0] p_exp[2][4];
    logic [3:0]  p_ovr_exp[2];

    initial begin
        p_pat[0]     = {12'h800, 12'h7FF, 12'h001, 12'hFFF};
        p_exp[0]     = '{18'h3FFFF, 18'h00001, 18'h007FF, 18'h3F800};
        p_ovr_exp[0] = 4'b0001;
        p_pat[1]     = {12'h001, 12'hFFF, 12'h800, 12'h123};
        p_exp[1]     = '{18'h00123, 18'h3F800, 18'h3FFFF, 18'h00001};
        p_ovr_exp[1] = 4'b0101;

        adc_rstn = 1'b0;
        adc_d_i  = {14'h2000, 14'h2000};
        dec_log2 = 3'd0;
        ovr_clr  = 1'b0;
        p_d_i    = {4{12'h100}};
        hdec[0]  = 0;  hdec[1] = 0;
        h0[0] = '0; h0[1] = '0; h1[0] = '0; h1[1] = '0;
        m_dec = 0;  m_s0 = 0;  m_s1 = 0;
        model_reset();

        repeat (2) @(posedge adc_clk);
        #2;
        check("rst_d_o", adc_d_o, 32'd0);
        check("rst_valid", 32'(adc_valid_o), 32'd0);
        check("rst_ovr", 32'(adc_ovr_o), 32'd0);
        check("clk_o", 32'(adc_clk_o), 32'd2);
        check("cdcs_o", 32'(adc_cdcs_o), 32'd1);
        check("par_rst_d_o", p_d_o[31:0], 32'd0);

        // Passthrough conversion.
        @(negedge adc_clk);
        adc_rstn = 1'b1;
        drive_now(14'h0000, 14'h2100, 1'b0, 0);
        drive(14'h3FFF, 14'h2101, 1'b0, 0);
        drive(14'h2000, 14'h1F00, 1'b0, 0);
        drive(14'h1FFF, 14'h2000, 1'b0, 0);

        // Second configuration: four independent 12-bit two's-complement channels.
        for (int p = 0; p < 2; p++) begin
            p_d_i = p_pat[p];
            repeat (3) drive(14'h2000, 14'h2000, 1'b0, 0);
            for (int ch = 0; ch < 4; ch++)
                check($sformatf("par_ch%0d", ch), 32'(p_d_o[ch*18 +: 18]), 32'(p_exp[p][ch]));
            check("par_ovr", 32'(p_ovr), 32'(p_ovr_exp[p]));
            check("par_valid", 32'(p_valid), 32'd1);
        end

        // Averaging over 4.
        for (int i = 0; i < 4; i++)
            drive(avg0[i], (i == 3) ? 14'h1FFE : 14'h1FFF, 1'b0, 2);
        repeat (8) drive(rnd(), rnd(), 1'b0, 2);

        // Length change on the 2nd sample of a frame: this frame stays at 4.
        drive(rnd(), rnd(), 1'b0, 2);
        repeat (7) drive(rnd(), rnd(), 1'b0, 1);

        // Request above the maximum clamps to 16.
        repeat (32) drive(rnd(), rnd(), 1'b0, 7);

        // Overrange: flush pipeline flags, then set/hold/clear.
        repeat (3) drive(14'h2000, 14'h2000, 1'b1, 0);
        drive(14'h2000, 14'h3FFF, 1'b0, 0);
        repeat (3) drive(14'h2000, 14'h2000, 1'b0, 0);
        drive(14'h2000, 14'h0000, 1'b0, 0);
        drive(14'h2000, 14'h2000, 1'b0, 0);
        drive(14'h2000, 14'h2000, 1'b1, 0);
        repeat (2) drive(14'h2000, 14'h2000, 1'b0, 0);
        drive(14'h2000, 14'h2000, 1'b1, 0);
        drive(14'h2000, 14'h2000, 1'b0, 0);

        // Reset in the middle of an 8-sample frame.
        drive(14'h3FFF, rnd(), 1'b0, 3);
        drive(rnd(), rnd(), 1'b0, 3);
        drive(rnd(), rnd(), 1'b0, 3);
        @(posedge adc_clk);
        #3;
        adc_rstn = 1'b0;
        model_reset();
        #1;
        check("mid_rst_d_o", adc_d_o, 32'd0);
        check("mid_rst_valid", 32'(adc_valid_o), 32'd0);
        check("mid_rst_ovr", 32'(adc_ovr_o), 32'd0);
        @(negedge adc_clk);
        adc_rstn = 1'b1;
        drive_now(rnd(), rnd(), 1'b0, 3);
        repeat (15) drive(rnd(), rnd(), 1'b0, 3);

        @(posedge adc_clk);
        #2;
        check("q_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
